// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle between control unit and serial subtractor.
// OVF is present only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
    logic [WIDTH-1:0] Y;
    logic             BOUT;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             OVF;
`endif

    modport master (
        output START, A, B, BIN,
        input  Y, BOUT, ZERO, BUSY, DONE
`ifdef SERIAL_SUB_OVERFLOW_EN
        , input OVF
`endif
    );

    modport slave (
        input  START, A, B, BIN,
        output Y, BOUT, ZERO, BUSY, DONE
`ifdef SERIAL_SUB_OVERFLOW_EN
        , output OVF
`endif
    );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor slice: D = A - B - BI, BO = borrow out.
module serial_subtractor_full_sub (
    output logic D,
    output logic BO,
    input  logic A,
    input  logic B,
    input  logic BI
);

    assign D  = A ^ B ^ BI;
    assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor Y = A - B - BIN, LSB first, one bit per clock with a registered borrow.
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
//
// state   | meaning
// IDLE    | waiting for START; last result held
// RUN     | shifting one bit per clock, BUSY=1
// DONE    | one-cycle DONE pulse; Y/BOUT/ZERO valid; START restarts
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input logic              CLK,
    input logic              RST,
    serial_subtractor_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   y_sh;
    logic [WIDTH-1:0]   y_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               bw_q;
    logic               bout_q;
    logic               zero_q;
    logic               busy;
    logic               done;
    logic               diff_bit;
    logic               borrow_out;
    logic               last_bit;

    serial_subtractor_full_sub u_slice (
        .D  (diff_bit),
        .BO (borrow_out),
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .BI (bw_q)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign y_next   = {diff_bit, y_sh[WIDTH-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = bus.START ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result flags are only written on the edge that enters DONE, so they hold through IDLE and RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_sh   <= '0;
            b_sh   <= '0;
            y_sh   <= '0;
            cnt_q  <= '0;
            bw_q   <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        bw_q  <= bus.BIN;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    y_sh  <= y_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    bw_q  <= borrow_out;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        bout_q <= borrow_out;
                        zero_q <= (y_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ovf_q;

    // On the last RUN edge bw_q is the borrow into the MSB and borrow_out the borrow out of it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_RUN && last_bit) begin
            ovf_q <= bw_q ^ borrow_out;
        end
    end

    assign bus.OVF = ovf_q;
`endif

    assign bus.Y    = y_sh;
    assign bus.BOUT = bout_q;
    assign bus.ZERO = zero_q;
    assign bus.BUSY = busy;
    assign bus.DONE = done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=32) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] exp_y;
    logic         exp_bout;
    logic         exp_zero;
    logic         exp_ovf;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        longint unsigned ua, ub, ud;
        longint          sa, sb, sd;
        ua = a;
        ub = b;
        ud = ua - ub - longint'(bin);
        exp_y    = ud[W-1:0];
        exp_bout = (ua < ub + longint'(bin));
        exp_zero = (exp_y == '0);
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        sd = sa - sb - longint'(bin);
        exp_ovf = (sd < -(longint'(1) << (W - 1))) || (sd > ((longint'(1) << (W - 1)) - 1));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_y"},    bus.Y,    0);
        check({tag, "_bout"}, bus.BOUT, 0);
        check({tag, "_zero"}, bus.ZERO, 0);
        check({tag, "_busy"}, bus.BUSY, 0);
        check({tag, "_done"}, bus.DONE, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"},  bus.OVF,  0);
`endif
    endtask

    // Called at a falling edge where the DUT is in IDLE or DONE; returns in the first RUN cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.A     = a;
        bus.B     = b;
        bus.BIN   = bin;
        bus.START = 1'b1;
        set_expect(a, b, bin);
        @(negedge clk);
        bus.START = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.BIN   = 1'($urandom % 2);
    endtask

    task automatic wait_done(input string tag, input bit pulse);
        int idx;
        int busy_cnt;
        idx      = 1;
        busy_cnt = 0;
        while (!bus.DONE && idx < 200) begin
            if (bus.BUSY) busy_cnt++;
            if (pulse && (idx == 5 || idx == 20)) begin
                bus.START = 1'b1;
                bus.A     = $urandom;
                bus.B     = $urandom;
                bus.BIN   = ~bus.BIN;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge clk);
            idx++;
        end
        bus.START = 1'b0;
        check({tag, "_latency"}, idx, 33);
        check({tag, "_busy_cycles"}, busy_cnt, 32);
        check({tag, "_y"},    bus.Y,    exp_y);
        check({tag, "_bout"}, bus.BOUT, exp_bout);
        check({tag, "_zero"}, bus.ZERO, exp_zero);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"},  bus.OVF,  exp_ovf);
`endif
    endtask

    task automatic idle_after(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.DONE, 0);
        check({tag, "_idle_busy"},  bus.BUSY, 0);
        check({tag, "_hold_y"},     bus.Y,    exp_y);
        check({tag, "_hold_bout"},  bus.BOUT, exp_bout);
        check({tag, "_hold_zero"},  bus.ZERO, exp_zero);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;
        bit           saw_done;

        rst       = 1'b1;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.BIN   = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        issue(32'd10, 32'd3, 1'b0);
        wait_done("sub_10_3", 0);
        check("sub_10_3_const", bus.Y, 7);
        idle_after("sub_10_3");

        issue(32'd3, 32'd10, 1'b0);
        wait_done("sub_3_10", 0);
        check("sub_3_10_const", bus.Y, 64'hFFFF_FFF9);
        idle_after("sub_3_10");

        issue(32'h8000_0000, 32'd1, 1'b0);
        wait_done("sub_min_1", 0);
        idle_after("sub_min_1");

        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        wait_done("sub_equal", 0);
        check("sub_equal_zero_const", bus.ZERO, 1);
        idle_after("sub_equal");

        issue(32'd0, 32'd0, 1'b1);
        wait_done("sub_0_0_bin", 0);
        check("sub_0_0_bin_const", bus.Y, 64'hFFFF_FFFF);
        idle_after("sub_0_0_bin");

        issue(32'h1234_5678, 32'h0000_1111, 1'b1);
        wait_done("start_in_run", 1);
        idle_after("start_in_run");

        issue(32'd100, 32'd1, 1'b0);
        wait_done("chain1", 0);
        issue(32'd5, 32'd9, 1'b1);
        check("chain_busy_next", bus.BUSY, 1);
        check("chain_done_low", bus.DONE, 0);
        wait_done("chain2", 0);
        idle_after("chain2");

        issue(32'd77, 32'd5, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("abort");
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DONE) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        issue(32'd1000, 32'd999, 1'b1);
        wait_done("after_abort", 0);
        idle_after("after_abort");

        for (int i = 0; i < 25; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom % 2);
            case ($urandom % 4)
                0: rb = ra;
                1: ra = '0;
                2: rb = ~ra;
                default: ;
            endcase
            issue(ra, rb, rbin);
            wait_done("random", 0);
            if ($urandom % 2 == 0) idle_after("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
